// File: rtl/cp0_unit_if.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : cp0_unit_if
// Description : Pipeline-side bus of the CP0 unit. The hazard/control logic
//               drives exception entry, eret, MTC0 and the MFC0 read address.
//               CP0 returns the read data, the EPC restore address and the
//               qualified interrupt request.
// Ports (master = pipeline, slave = cp0_unit):
//   stall_i             memory stall, freezes pipeline-originated writes
//   exc_w_en/exc_code/exc_epc   exception entry strobe, ExcCode, return PC
//   eret                eret in MEM stage
//   mtc0_en/mtc0_addr/mtc0_data MTC0 write port
//   mfc0_addr/mfc0_data MFC0 read port (combinational data)
//   epc_o               current EPC
//   cp0_intr            qualified interrupt request
// Revision    : 1.0 - initial release
// ============================================================================
interface cp0_unit_if;
  logic        stall_i;
  logic        exc_w_en;
  logic [4:0]  exc_code;
  logic [31:0] exc_epc;
  logic        eret;
  logic        mtc0_en;
  logic [4:0]  mtc0_addr;
  logic [31:0] mtc0_data;
  logic [4:0]  mfc0_addr;
  logic [31:0] mfc0_data;
  logic [31:0] epc_o;
  logic        cp0_intr;

  modport master (
    output stall_i, exc_w_en, exc_code, exc_epc, eret,
           mtc0_en, mtc0_addr, mtc0_data, mfc0_addr,
    input  mfc0_data, epc_o, cp0_intr
  );

  modport slave (
    input  stall_i, exc_w_en, exc_code, exc_epc, eret,
           mtc0_en, mtc0_addr, mtc0_data, mfc0_addr,
    output mfc0_data, epc_o, cp0_intr
  );
endinterface
`default_nettype wire

// File: rtl/cp0_unit.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : cp0_unit
// Description : Coprocessor-0 register file and interrupt source for the
//               5-stage MIPS pipeline. Holds Count, Compare, Status, Cause
//               and EPC, services MTC0/MFC0, runs the Count/Compare timer and
//               qualifies the interrupt request.
// Ports:
//   clk      core clock, all state updates on posedge
//   reset    asynchronous, active-high reset
//   hw_intr  external level interrupt lines (asynchronous to clk)
//   bus      pipeline bus (cp0_unit_if.slave)
// Revision    : 1.0 - initial release
// ============================================================================
module cp0_unit #(
  parameter int          TICK_DIV    = 2,
  parameter logic [31:0] COMPARE_RST = 32'hFFFF_FFFF
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [4:0]   hw_intr,
  cp0_unit_if.slave    bus
);

  localparam int            TW         = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [TW-1:0] TICK_LAST  = TW'(TICK_DIV - 1);
  localparam logic [4:0]    ADDR_COUNT   = 5'd9;
  localparam logic [4:0]    ADDR_COMPARE = 5'd11;
  localparam logic [4:0]    ADDR_STATUS  = 5'd12;
  localparam logic [4:0]    ADDR_CAUSE   = 5'd13;
  localparam logic [4:0]    ADDR_EPC     = 5'd14;

  logic [4:0]    sync_1, sync_2;
  logic [TW-1:0] tick;
  logic [31:0]   count, compare, epc;
  logic          timer_pend;
  logic          ie, exl;
  logic [7:0]    im;
  logic [4:0]    exc_code_r;
  logic [1:0]    ip_sw;
  logic [7:0]    ip;

  // Pipeline-originated writes are frozen while stalled; the pipeline
  // re-presents them once the stall releases.
  logic exc_go, eret_go, mtc_go;
  logic wr_count, wr_compare, wr_status, wr_cause, wr_epc;

  assign exc_go     = bus.exc_w_en & ~bus.stall_i;
  assign eret_go    = bus.eret     & ~bus.stall_i;
  assign mtc_go     = bus.mtc0_en  & ~bus.stall_i;
  assign wr_count   = mtc_go & (bus.mtc0_addr == ADDR_COUNT);
  assign wr_compare = mtc_go & (bus.mtc0_addr == ADDR_COMPARE);
  assign wr_status  = mtc_go & (bus.mtc0_addr == ADDR_STATUS);
  assign wr_cause   = mtc_go & (bus.mtc0_addr == ADDR_CAUSE);
  assign wr_epc     = mtc_go & (bus.mtc0_addr == ADDR_EPC);

  // IP7 timer, IP6..IP2 synchronised hardware lines (level), IP1..IP0 software
  assign ip = {timer_pend, sync_2, ip_sw};

  // Two-flop synchroniser on the external lines
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_1 <= '0;
      sync_2 <= '0;
    end else begin
      sync_1 <= hw_intr;
      sync_2 <= sync_1;
    end
  end

  // Timer: runs regardless of stall and EXL
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tick       <= '0;
      count      <= '0;
      compare    <= COMPARE_RST;
      timer_pend <= 1'b0;
    end else begin
      if (wr_count) begin
        count <= bus.mtc0_data;
        tick  <= '0;
      end else if (tick == TICK_LAST) begin
        count <= count + 32'd1;
        tick  <= '0;
      end else begin
        tick  <= tick + TW'(1);
      end

      // A Compare write clears pending and wins over a same-cycle match
      if (wr_compare) begin
        compare    <= bus.mtc0_data;
        timer_pend <= 1'b0;
      end else if (count == compare) begin
        timer_pend <= 1'b1;
      end
    end
  end

  // Status / Cause / EPC. Exception entry owns EXL, ExcCode and EPC; the
  // non-conflicting MTC0 fields (IE, IM, IP[1:0]) still apply alongside it.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ie         <= 1'b0;
      exl        <= 1'b0;
      im         <= '0;
      exc_code_r <= '0;
      ip_sw      <= '0;
      epc        <= '0;
    end else begin
      if (wr_status) begin
        ie <= bus.mtc0_data[0];
        im <= bus.mtc0_data[15:8];
      end

      if (exc_go)
        exl <= 1'b1;
      else if (wr_status)
        exl <= bus.mtc0_data[1];
      else if (eret_go)
        exl <= 1'b0;

      if (exc_go)
        exc_code_r <= bus.exc_code;

      if (wr_cause)
        ip_sw <= bus.mtc0_data[9:8];

      if (exc_go)
        epc <= bus.exc_epc;
      else if (wr_epc)
        epc <= bus.mtc0_data;
    end
  end

  // MFC0 read: current state only, no bypass of a same-cycle write
  always_comb begin
    bus.mfc0_data = '0;
    case (bus.mfc0_addr)
      ADDR_COUNT:   bus.mfc0_data = count;
      ADDR_COMPARE: bus.mfc0_data = compare;
      ADDR_STATUS:  bus.mfc0_data = {16'd0, im, 6'd0, exl, ie};
      ADDR_CAUSE:   bus.mfc0_data = {16'd0, ip, 1'b0, exc_code_r, 2'd0};
      ADDR_EPC:     bus.mfc0_data = epc;
      default:      bus.mfc0_data = '0;
    endcase
  end

  assign bus.epc_o    = epc;
  assign bus.cp0_intr = ie & ~exl & (|(ip & im)) & ~bus.stall_i & ~bus.eret;

endmodule
`default_nettype wire

// File: tb/tb_cp0_unit.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_cp0_unit
// Description : Self-checking bench for cp0_unit. Expected observations are
//               queued as stimulus is driven and drained against the DUT
//               1 ns after the active edge.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_cp0_unit;
  localparam int TICK_DIV = 2;
  localparam int K_REG  = 0;
  localparam int K_INTR = 1;
  localparam int K_EPC  = 2;

  logic       clk = 1'b0;
  logic       reset;
  logic [4:0] hw_intr;

  cp0_unit_if bus ();

  cp0_unit #(.TICK_DIV(TICK_DIV), .COMPARE_RST(32'hFFFF_FFFF)) dut (
    .clk     (clk),
    .reset   (reset),
    .hw_intr (hw_intr),
    .bus     (bus)
  );

  always #50 clk = ~clk;

  typedef struct {
    string       tag;
    int          kind;
    logic [4:0]  addr;
    logic [31:0] val;
  } exp_t;

  exp_t        sb_q[$];
  int          checks   = 0;
  int          failures = 0;
  logic [31:0] m_count  = 0;
  int          m_tick   = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic expect_reg(input string tag, input logic [4:0] addr, input logic [31:0] v);
    sb_q.push_back('{tag, K_REG, addr, v});
  endtask

  task automatic expect_intr(input string tag, input logic v);
    sb_q.push_back('{tag, K_INTR, 5'd0, {31'd0, v}});
  endtask

  task automatic expect_epc(input string tag, input logic [31:0] v);
    sb_q.push_back('{tag, K_EPC, 5'd0, v});
  endtask

  task automatic drain();
    exp_t e;
    while (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      if (e.kind == K_REG) begin
        bus.mfc0_addr = e.addr;
        #1;
        check_val(e.tag, bus.mfc0_data, e.val);
      end else if (e.kind == K_INTR) begin
        #1;
        check_val(e.tag, {31'd0, bus.cp0_intr}, e.val);
      end else begin
        #1;
        check_val(e.tag, bus.epc_o, e.val);
      end
    end
  endtask

  // One clock edge; also advances the bench's Count model.
  task automatic tick();
    logic        wr_cnt;
    logic [31:0] d;
    wr_cnt = bus.mtc0_en && !bus.stall_i && (bus.mtc0_addr == 5'd9);
    d      = bus.mtc0_data;
    @(posedge clk);
    #1;
    if (reset) begin
      m_count = 0;
      m_tick  = 0;
    end else if (wr_cnt) begin
      m_count = d;
      m_tick  = 0;
    end else if (m_tick == TICK_DIV - 1) begin
      m_count = m_count + 1;
      m_tick  = 0;
    end else begin
      m_tick++;
    end
  endtask

  task automatic mtc(input logic [4:0] addr, input logic [31:0] data);
    bus.mtc0_en   = 1'b1;
    bus.mtc0_addr = addr;
    bus.mtc0_data = data;
    tick();
    bus.mtc0_en   = 1'b0;
  endtask

  task automatic exc(input logic [4:0] code, input logic [31:0] pc);
    bus.exc_w_en = 1'b1;
    bus.exc_code = code;
    bus.exc_epc  = pc;
    tick();
    bus.exc_w_en = 1'b0;
  endtask

  task automatic run_until_count(input logic [31:0] target);
    for (int i = 0; i < 200 && m_count != target; i++) tick();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1;
    hw_intr = '0;
    bus.stall_i = 0; bus.exc_w_en = 0; bus.exc_code = '0; bus.exc_epc = '0;
    bus.eret = 0; bus.mtc0_en = 0; bus.mtc0_addr = '0; bus.mtc0_data = '0;
    bus.mfc0_addr = '0;
    tick(); tick();
    reset = 1'b0;

    // ---------------- Reset mid-count ----------------
    mtc(5'd9, 32'h1234);
    mtc(5'd12, 32'h2);
    tick();
    expect_reg("cnt_run", 5'd9, m_count);
    expect_reg("status_exl", 5'd12, 32'h2);
    drain();
    #1 reset = 1'b1;
    m_count = 0; m_tick = 0;
    expect_reg("rst_count", 5'd9, 32'h0);
    expect_reg("rst_compare", 5'd11, 32'hFFFF_FFFF);
    expect_reg("rst_status", 5'd12, 32'h0);
    expect_reg("rst_cause", 5'd13, 32'h0);
    expect_reg("rst_epc", 5'd14, 32'h0);
    expect_reg("rst_addr0", 5'd0, 32'h0);
    expect_intr("rst_intr", 1'b0);
    expect_epc("rst_epc_o", 32'h0);
    drain();
    tick();
    reset = 1'b0;

    // ---------------- Timer ----------------
    mtc(5'd11, 32'd5);
    mtc(5'd12, 32'h8001);
    run_until_count(32'd5);
    expect_reg("cnt_at_cmp", 5'd9, 32'd5);
    expect_intr("intr_pre_match", 1'b0);
    drain();
    tick();
    expect_reg("cause_ip7", 5'd13, 32'h8000);
    expect_intr("intr_timer", 1'b1);
    drain();
    mtc(5'd11, 32'd20);
    expect_reg("compare_20", 5'd11, 32'd20);
    expect_reg("cause_ip7_clr", 5'd13, 32'h0);
    expect_intr("intr_cleared", 1'b0);
    drain();
    run_until_count(32'd20);
    tick();
    expect_intr("intr_timer20", 1'b1);
    drain();

    // ---------------- Exception entry / eret ----------------
    exc(5'd8, 32'h00F0_0100);
    expect_reg("epc_entry", 5'd14, 32'h00F0_0100);
    expect_reg("cause_entry", 5'd13, 32'h8020);
    expect_reg("status_entry", 5'd12, 32'h8003);
    expect_intr("intr_masked_exl", 1'b0);
    drain();
    bus.eret = 1'b1;
    expect_epc("epc_o_eret", 32'h00F0_0100);
    expect_intr("intr_during_eret", 1'b0);
    drain();
    tick();
    bus.eret = 1'b0;
    expect_reg("status_eret", 5'd12, 32'h8001);
    expect_intr("intr_reraise", 1'b1);
    drain();
    exc(5'd8, 32'h00F0_0200);
    exc(5'd0, 32'h00F0_0300);
    expect_reg("epc_nested", 5'd14, 32'h00F0_0300);
    expect_reg("cause_nested", 5'd13, 32'h8000);
    drain();
    mtc(5'd12, 32'h0);

    // ---------------- External line ----------------
    mtc(5'd11, 32'hFFFF_FFFF);
    mtc(5'd12, 32'h0401);
    expect_reg("cause_clean", 5'd13, 32'h0);
    hw_intr = 5'b00001;
    expect_intr("hw_lat0", 1'b0);
    drain();
    tick();
    expect_intr("hw_lat1", 1'b0);
    drain();
    tick();
    expect_intr("hw_lat2", 1'b1);
    expect_reg("cause_ip2", 5'd13, 32'h0400);
    drain();
    hw_intr = 5'b0;
    tick();
    expect_intr("hw_fall1", 1'b1);
    drain();
    tick();
    expect_intr("hw_fall2", 1'b0);
    drain();
    mtc(5'd12, 32'h0400);
    hw_intr = 5'b00001;
    tick(); tick(); tick();
    expect_intr("hw_ie0", 1'b0);
    expect_reg("cause_ie0", 5'd13, 32'h0400);
    drain();

    // ---------------- Stall ----------------
    mtc(5'd12, 32'h0401);
    expect_intr("pre_stall_intr", 1'b1);
    drain();
    bus.stall_i  = 1'b1;
    bus.exc_w_en = 1'b1; bus.exc_code = 5'd8; bus.exc_epc = 32'h0000_1110;
    bus.eret     = 1'b1;
    bus.mtc0_en  = 1'b1; bus.mtc0_addr = 5'd14; bus.mtc0_data = 32'hABCD_0000;
    expect_intr("stall_intr", 1'b0);
    drain();
    for (int i = 0; i < 4; i++) tick();
    expect_reg("stall_status", 5'd12, 32'h0401);
    expect_reg("stall_epc", 5'd14, 32'h00F0_0300);
    expect_reg("stall_cause", 5'd13, 32'h0400);
    expect_reg("stall_count", 5'd9, m_count);
    drain();
    bus.stall_i = 1'b0;
    tick();
    bus.exc_w_en = 1'b0; bus.eret = 1'b0; bus.mtc0_en = 1'b0;
    expect_reg("rel_status", 5'd12, 32'h0403);
    expect_reg("rel_epc", 5'd14, 32'h0000_1110);
    expect_reg("rel_cause", 5'd13, 32'h0420);
    expect_intr("rel_intr", 1'b0);
    drain();

    // ---------------- Collisions and misc ----------------
    mtc(5'd12, 32'h0);
    hw_intr = 5'b0;
    bus.mtc0_en = 1'b1; bus.mtc0_addr = 5'd12; bus.mtc0_data = 32'h0003;
    exc(5'd0, 32'h0000_2220);
    bus.mtc0_en = 1'b0;
    expect_reg("col_status", 5'd12, 32'h0003);
    expect_reg("col_epc", 5'd14, 32'h0000_2220);
    drain();
    tick(); tick();
    mtc(5'd13, 32'hFFFF_FFFF);
    expect_reg("cause_sw", 5'd13, 32'h0300);
    mtc(5'd5, 32'hDEAD_BEEF);
    expect_reg("unmapped", 5'd5, 32'h0);
    expect_reg("final_count", 5'd9, m_count);
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
`default_nettype wire

// File: doc/cp0_unit.md
Name: cp0_unit

Overview:
- Coprocessor-0 register file and interrupt source for the 5-stage MIPS pipeline.
- Consumes the exception-entry strobe, exception code, EPC and eret from the hazard/control logic.
- Returns the qualified interrupt request and the EPC restore address.
- Holds Count, Compare, Status, Cause and EPC. Services MTC0/MFC0 and the timer.

Parameters:
TICK_DIV, 2, core clocks per Count increment (>=1)
COMPARE_RST, 32'hFFFFFFFF, Compare reset value

Ports:
clk  in  1  core clock, all state updates on posedge
reset  in  1  reset, asynchronous, active-high
stall_i  in  1  memory stall; freezes pipeline-originated writes
hw_intr  in  5  external level interrupt lines, asynchronous to clk
exc_w_en  in  1  exception entry strobe (interrupt or syscall)
exc_code  in  5  ExcCode to record (0 = Int, 8 = Sys)
exc_epc  in  32  faulting/return PC to record
eret  in  1  eret instruction in MEM stage
mtc0_en  in  1  MTC0 write enable
mtc0_addr  in  5  destination CP0 register number
mtc0_data  in  32  write data
mfc0_addr  in  5  read register number
mfc0_data  out  32  combinational read data
epc_o  out  32  current EPC, for the eret target
cp0_intr  out  1  qualified interrupt request to the control unit

Behaviour:
- Register map:
  - 9 = Count
  - 11 = Compare
  - 12 = Status: bit0 IE, bit1 EXL, bits[15:8] IM
  - 13 = Cause: bits[6:2] ExcCode, bits[15:8] IP
  - 14 = EPC
  - Other addresses read 0; writes to them are ignored.
- Reset values:
  - Count 0, Compare COMPARE_RST, Status 0, Cause 0, EPC 0.
  - Tick counter 0, sync flops 0, timer-pending 0.
  - Outputs: mfc0_data = Count at addr 0 → 0; epc_o 0; cp0_intr 0.
- hw_intr synchronisation:
  - 2-flop synchroniser per line.
  - IP[6:2] = synced hw_intr[4:0], level, not sticky; 2-cycle latency from pin to IP.
- Software interrupts:
  - IP[1:0] are the only software-writable Cause bits.
  - An MTC0 to Cause writes IP[1:0] only.
- Timer:
  - The tick counter counts 0..TICK_DIV-1. Count += 1 (mod 2^32, wrap silently) when the tick counter is at TICK_DIV-1.
  - In any cycle where Count == Compare, the sticky timer-pending bit is set.
  - IP7 = timer-pending.
  - An MTC0 to Compare loads Compare and clears timer-pending in the same edge. A clear caused by the write beats a set caused by a match in that same cycle.
  - An MTC0 to Count loads Count and resets the tick counter to 0.
  - The timer runs regardless of stall_i and EXL.
- Interrupt qualification:
  - cp0_intr = IE & ~EXL & |(IP & IM) & ~stall_i & ~eret. Combinational from registered state.
- Exception entry (exc_w_en=1, stall_i=0):
  - EPC <= exc_epc, ExcCode <= exc_code, EXL <= 1. IE is unchanged.
  - cp0_intr drops the next cycle via EXL.
  - A second exc_w_en while EXL=1 still overwrites EPC and ExcCode (syscall nested in a handler).
- eret (stall_i=0): EXL <= 0; epc_o presents EPC in the same cycle.
- Stall: while stall_i=1, exc_w_en, eret and mtc0_en are ignored. They are re-presented by the frozen pipeline after the stall.
- Simultaneous events, same cycle:
  - exc_w_en beats eret; EXL ends at 1.
  - exc_w_en beats MTC0 to Status/Cause/EPC for the fields it writes. The non-conflicting fields of the MTC0 (IE, IM, IP[1:0]) still apply.
  - MTC0 to Count/Compare is unaffected by an exception.
- MFC0 reads are combinational from current register state. There is no same-cycle write bypass: the new value is visible the cycle after the write.

Test Plan:
- Reset: assert reset mid-count with Count=0x1234 and EXL=1 → all registers at their reset values immediately; cp0_intr=0; reading addr 11 gives 0xFFFFFFFF.
- Timer: TICK_DIV=2, write Compare=5, Status=0x8001 → IP7 sets once Count=5 (~10 cycles) and cp0_intr=1. Writing Compare=20 clears IP7 and drops cp0_intr.
- Entry/eret: exc_w_en with exc_code=8, exc_epc=0x00F00100 → next cycle EPC=0x00F00100, Cause[6:2]=8, EXL=1, cp0_intr masked. eret → EXL=0, epc_o=0x00F00100, and pending IP7 re-raises cp0_intr.
- External line: Status=0x0401, pulse hw_intr[0] high → cp0_intr rises exactly 2 cycles later and follows the level. With Status=0x0400 (IE=0), cp0_intr stays 0.
- Stall: hold stall_i=1 with exc_w_en, eret and mtc0_en asserted → no register change, cp0_intr=0, Count still increments. Release → the writes take effect.
- Collision: exc_w_en and eret in the same cycle → EXL=1. exc_w_en plus an MTC0 of Status=0x0003 → IE=1, EXL=1, EPC comes from exc_epc.
